// File: rtl/core_seq_ctrl.sv
// Multicycle FETCH/DECODE/MEM/WB sequencer for TinyRisc-V; owns the architectural PC.
// 3 cycles per ALU/branch/jump, 4 per load/store with same-cycle acks; requests hold until ack or timeout.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0100,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic [6:0]  opcode,
    input  logic        wb_reg,
    input  logic [4:0]  rd_num,
    input  logic [31:0] rd_data,
    input  logic [31:0] imm,
    input  logic [1:0]  pc_sel,
    input  logic        br_taken,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] retire_cnt,
    output logic        error
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_WB, S_ERR} state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, npc_q;
    logic        imem_req_q, dmem_req_q, dmem_we_q, load_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q, retire_q, wait_q;
    logic        error_q;

    logic [31:0] ea_d, npc_d;
    logic        is_load_d, is_store_d, timeout_d;

    always_comb begin
        ea_d       = rs1_data + imm;
        is_load_d  = (opcode == OP_LOAD);
        is_store_d = (opcode == OP_STORE);
        npc_d      = pc_q + 32'd4;
        case (pc_sel)
            2'd1:    if (br_taken) npc_d = pc_q + imm;
            2'd2:    npc_d = pc_q + imm;
            2'd3:    npc_d = ea_d & ~32'h1;
            default: npc_d = pc_q + 32'd4;
        endcase
        // The cycle that would make the count reach the limit is the last one an ack may arrive in.
        timeout_d  = (TIMEOUT_CYCLES != 0) && (wait_q + 32'd1 == TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= NOP;
            npc_q        <= RESET_PC;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            load_q       <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            retire_q     <= 32'd0;
            error_q      <= 1'b0;
            wait_q       <= 32'd0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // Request comes up one cycle after reset; waits only count while it is raised.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        wait_q     <= 32'd0;
                        state_q    <= S_DECODE;
                    end else if (timeout_d) begin
                        imem_req_q <= 1'b0;
                        error_q    <= 1'b1;
                        wait_q     <= 32'd0;
                        state_q    <= S_ERR;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    if (is_load_d || is_store_d) begin
                        dmem_addr_q  <= ea_d;
                        dmem_wdata_q <= rs2_data;
                        dmem_we_q    <= is_store_d;
                        dmem_req_q   <= 1'b1;
                        load_q       <= is_load_d;
                        npc_q        <= pc_q + 32'd4;
                        state_q      <= S_MEM;
                    end else begin
                        rf_waddr_q <= rd_num;
                        rf_wdata_q <= rd_data;
                        rf_we_q    <= wb_reg && (rd_num != 5'd0);
                        npc_q      <= npc_d;
                        state_q    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        wait_q     <= 32'd0;
                        if (load_q) begin
                            rf_wdata_q <= dmem_rdata;
                            rf_waddr_q <= rd_num;
                            rf_we_q    <= (rd_num != 5'd0);
                        end
                        state_q <= S_WB;
                    end else if (timeout_d) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        error_q    <= 1'b1;
                        wait_q     <= 32'd0;
                        state_q    <= S_ERR;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    retire_q <= retire_q + 32'd1;
                    if (npc_q[1:0] != 2'b00) begin
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        pc_q       <= npc_q;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_ERR: state_q <= S_ERR;
                default: begin
                    error_q <= 1'b1;
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign retire_cnt = retire_q;
    assign error      = error_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: plays imem, dmem and decode; fixed vectors, corner sequences, random program.
module tb_core_seq_ctrl;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_LW   = 7'b0000011;
    localparam logic [6:0]  OP_SW   = 7'b0100011;
    localparam logic [6:0]  OP_ALU  = 7'b0110011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam int          NVEC    = 14;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0, ir, pc;
    logic [6:0]  opcode = 7'd0;
    logic        wb_reg = 1'b0, br_taken = 1'b0;
    logic [4:0]  rd_num = 5'd0;
    logic [31:0] rd_data = 32'd0, imm = 32'd0, rs1_data = 32'd0, rs2_data = 32'd0;
    logic [1:0]  pc_sel = 2'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic        rf_we, error;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, retire_cnt;

    always #5 clk = ~clk;

    core_seq_ctrl #(.RESET_PC(32'h0000_0100), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc),
        .opcode(opcode), .wb_reg(wb_reg), .rd_num(rd_num), .rd_data(rd_data), .imm(imm),
        .pc_sel(pc_sel), .br_taken(br_taken), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_cnt(retire_cnt), .error(error)
    );

    typedef struct {
        logic [31:0] word;
        logic [6:0]  opc;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [31:0] imm;
        logic [1:0]  sel;
        logic        br;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          idly;
        int          ddly;
        logic [31:0] drdata;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] daddr;
        logic        err;
    } exp_t;

    typedef struct {
        instr_t stim;
        exp_t   want;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_dec(input instr_t t);
        opcode   = t.opc;
        wb_reg   = t.wb;
        rd_num   = t.rd;
        rd_data  = t.rd_data;
        imm      = t.imm;
        pc_sel   = t.sel;
        br_taken = t.br;
        rs1_data = t.rs1;
        rs2_data = t.rs2;
    endtask

    task automatic fetch(input logic [31:0] word, input int dly, input logic [31:0] pc0,
                         input string tag, output bit ok);
        int n;
        bit held;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        ok = (imem_req === 1'b1);
        chk({tag, ".imem_req"}, imem_req, 1);
        if (ok) begin
            chk({tag, ".imem_addr"}, imem_addr, pc0);
            held = 1'b1;
            for (int k = 0; k <= dly; k++) begin
                held       = held && (imem_req === 1'b1);
                imem_ack   = (k == dly);
                imem_rdata = (k == dly) ? word : $urandom;
                @(negedge clk);
            end
            imem_ack = 1'b0;
            chk({tag, ".imem_hold"}, held, 1);
            chk({tag, ".ir"}, ir, word);
            chk({tag, ".imem_drop"}, imem_req, 0);
        end
    endtask

    task automatic run_instr(input instr_t t, input exp_t e, input logic [31:0] pc0,
                             input logic [31:0] ret0, input string tag);
        bit ok, held, mem;
        mem = (t.opc == OP_LW) || (t.opc == OP_SW);
        fetch(t.word, t.idly, pc0, tag, ok);
        if (ok) begin
            chk({tag, ".rf_we_dec"}, rf_we, 0);
            drive_dec(t);
            @(negedge clk);
            if (mem) begin
                chk({tag, ".dmem_req"}, dmem_req, 1);
                chk({tag, ".dmem_addr"}, dmem_addr, e.daddr);
                chk({tag, ".dmem_we"}, dmem_we, (t.opc == OP_SW));
                if (t.opc == OP_SW) chk({tag, ".dmem_wdata"}, dmem_wdata, t.rs2);
                held = 1'b1;
                for (int k = 0; k <= t.ddly; k++) begin
                    held       = held && (dmem_req === 1'b1);
                    dmem_ack   = (k == t.ddly);
                    dmem_rdata = (k == t.ddly) ? t.drdata : $urandom;
                    @(negedge clk);
                end
                dmem_ack = 1'b0;
                chk({tag, ".dmem_hold"}, held, 1);
            end
            chk({tag, ".dmem_req_wb"}, dmem_req, 0);
            chk({tag, ".rf_we"}, rf_we, e.we);
            if (e.we) begin
                chk({tag, ".rf_waddr"}, rf_waddr, e.waddr);
                chk({tag, ".rf_wdata"}, rf_wdata, e.wdata);
            end
            chk({tag, ".pc_wb"}, pc, pc0);
            @(negedge clk);
            chk({tag, ".pc"}, pc, e.pc);
            chk({tag, ".retire"}, retire_cnt, ret0 + 32'd1);
            chk({tag, ".error"}, error, e.err);
            chk({tag, ".rf_we_after"}, rf_we, 0);
            chk({tag, ".imem_req_after"}, imem_req, !e.err);
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    function automatic exp_t model(input instr_t t, input logic [31:0] pc0);
        exp_t e;
        logic [31:0] npc;
        bit ld, st;
        ld      = (t.opc == OP_LW);
        st      = (t.opc == OP_SW);
        e.daddr = t.rs1 + t.imm;
        if (ld || st)        npc = pc0 + 4;
        else if (t.sel == 0) npc = pc0 + 4;
        else if (t.sel == 1) npc = t.br ? pc0 + t.imm : pc0 + 4;
        else if (t.sel == 2) npc = pc0 + t.imm;
        else                 npc = (t.rs1 + t.imm) - ((t.rs1 + t.imm) % 2);
        e.err   = (npc % 4) != 0;
        e.pc    = e.err ? pc0 : npc;
        e.we    = ld ? (t.rd != 0) : (st ? 1'b0 : (t.wb && t.rd != 0));
        e.waddr = t.rd;
        e.wdata = ld ? t.drdata : t.rd_data;
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind      = $urandom_range(0, 5);
        t.word    = $urandom;
        t.wb      = 1'($urandom);
        t.rd      = 5'($urandom);
        t.rd_data = $urandom;
        t.imm     = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
        t.sel     = 2'($urandom);
        t.br      = 1'($urandom);
        t.rs1     = $urandom;
        t.rs2     = $urandom;
        t.idly    = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
        t.ddly    = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
        t.drdata  = $urandom;
        case (kind)
            0:       begin t.opc = OP_ALU; t.sel = 2'd0; end
            1:       t.opc = OP_LW;
            2:       t.opc = OP_SW;
            3:       begin t.opc = OP_BR; t.sel = 2'd1; end
            4:       begin t.opc = OP_JAL; t.sel = 2'd2; end
            default: begin
                t.opc = OP_JALR;
                t.sel = 2'd3;
                t.rs1 = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
            end
        endcase
        return t;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        exp_t   e;
        logic [31:0] pc_m, ret_m;
        bit ok, held;
        int n;

        //             word          opc      wb    rd     rd_data        imm            sel   br    rs1            rs2            id  dd  drdata
        vecs[0]  = '{'{32'h002081B3, OP_ALU,  1'b1, 5'd3,  32'd11,        32'd0,         2'd0, 1'b0, 32'd1,         32'd2,         0,  0,  32'd0},
                     '{32'h104, 1'b1, 5'd3,  32'd11,        32'd0,     1'b0}};
        vecs[1]  = '{'{32'h02A0A103, OP_LW,   1'b1, 5'd2,  32'd0,         32'd42,        2'd0, 1'b0, 32'd8,         32'd0,         0,  3,  32'hDEADBEEF},
                     '{32'h104, 1'b1, 5'd2,  32'hDEADBEEF,  32'h32,    1'b0}};
        vecs[2]  = '{'{32'h00209A63, OP_BR,   1'b0, 5'd20, 32'h55,        32'h14,        2'd1, 1'b1, 32'd5,         32'd6,         0,  0,  32'd0},
                     '{32'h114, 1'b0, 5'd20, 32'd0,         32'd0,     1'b0}};
        vecs[3]  = '{'{32'h00209A63, OP_BR,   1'b0, 5'd20, 32'h55,        32'h14,        2'd1, 1'b0, 32'd5,         32'd5,         0,  0,  32'd0},
                     '{32'h104, 1'b0, 5'd20, 32'd0,         32'd0,     1'b0}};
        vecs[4]  = '{'{32'h000080E7, OP_JALR, 1'b1, 5'd1,  32'h104,       32'd0,         2'd3, 1'b0, 32'h201,       32'd0,         0,  0,  32'd0},
                     '{32'h200, 1'b1, 5'd1,  32'h104,       32'd0,     1'b0}};
        vecs[5]  = '{'{32'h000080E7, OP_JALR, 1'b1, 5'd1,  32'h104,       32'd0,         2'd3, 1'b0, 32'h202,       32'd0,         0,  0,  32'd0},
                     '{32'h100, 1'b1, 5'd1,  32'h104,       32'd0,     1'b1}};
        vecs[6]  = '{'{32'hFE112E23, OP_SW,   1'b0, 5'd28, 32'd0,         32'hFFFFFFFC,  2'd0, 1'b0, 32'h1000,      32'hCAFEF00D,  1,  1,  32'd0},
                     '{32'h104, 1'b0, 5'd28, 32'd0,         32'hFFC,   1'b0}};
        vecs[7]  = '{'{32'h00000033, OP_ALU,  1'b1, 5'd0,  32'd77,        32'd0,         2'd0, 1'b0, 32'd0,         32'd0,         0,  0,  32'd0},
                     '{32'h104, 1'b0, 5'd0,  32'd0,         32'd0,     1'b0}};
        vecs[8]  = '{'{32'h040000EF, OP_JAL,  1'b1, 5'd1,  32'h104,       32'h40,        2'd2, 1'b0, 32'd0,         32'd0,         2,  0,  32'd0},
                     '{32'h140, 1'b1, 5'd1,  32'h104,       32'd0,     1'b0}};
        vecs[9]  = '{'{32'h002081B3, OP_ALU,  1'b1, 5'd3,  32'd9,         32'd0,         2'd0, 1'b0, 32'd0,         32'd0,         15, 0,  32'd0},
                     '{32'h104, 1'b1, 5'd3,  32'd9,         32'd0,     1'b0}};
        vecs[10] = '{'{32'h01002003, OP_LW,   1'b1, 5'd0,  32'd0,         32'h10,        2'd0, 1'b0, 32'h20,        32'd0,         0,  15, 32'h1234},
                     '{32'h104, 1'b0, 5'd0,  32'd0,         32'h30,    1'b0}};
        vecs[11] = '{'{32'hF01FF2EF, OP_JAL,  1'b1, 5'd5,  32'h104,       32'hFFFFFF00,  2'd2, 1'b0, 32'd0,         32'd0,         0,  0,  32'd0},
                     '{32'h000, 1'b1, 5'd5,  32'h104,       32'd0,     1'b0}};
        vecs[12] = '{'{32'h00208163, OP_BR,   1'b0, 5'd2,  32'd0,         32'd2,         2'd1, 1'b1, 32'd0,         32'd0,         0,  0,  32'd0},
                     '{32'h100, 1'b0, 5'd2,  32'd0,         32'd0,     1'b1}};
        vecs[13] = '{'{32'h0200A383, OP_LW,   1'b0, 5'd7,  32'd0,         32'h20,        2'd0, 1'b0, 32'hFFFFFFF0,  32'd0,         0,  0,  32'hA5A5A5A5},
                     '{32'h104, 1'b1, 5'd7,  32'hA5A5A5A5,  32'h10,    1'b0}};

        // Reset state.
        do_reset();
        chk("rst.pc", pc, 32'h100);
        chk("rst.ir", ir, NOP);
        chk("rst.imem_req", imem_req, 0);
        chk("rst.dmem_req", dmem_req, 0);
        chk("rst.dmem_we", dmem_we, 0);
        chk("rst.rf_we", rf_we, 0);
        chk("rst.dmem_addr", dmem_addr, 0);
        chk("rst.dmem_wdata", dmem_wdata, 0);
        chk("rst.rf_waddr", rf_waddr, 0);
        chk("rst.rf_wdata", rf_wdata, 0);
        chk("rst.retire", retire_cnt, 0);
        chk("rst.error", error, 0);

        // An ack while no fetch is requested must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_ack.ir", ir, NOP);
        chk("stray_ack.imem_req", imem_req, 1);
        run_instr(vecs[0].stim, vecs[0].want, 32'h100, 32'd0, "stray_ack.add");

        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            run_instr(vecs[i].stim, vecs[i].want, 32'h100, 32'd0, $sformatf("vec%0d", i));
        end

        // Terminal error state ignores acks and freezes everything.
        do_reset();
        run_instr(vecs[5].stim, vecs[5].want, 32'h100, 32'd0, "err");
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk("err.imem_req", imem_req, 0);
        chk("err.dmem_req", dmem_req, 0);
        chk("err.rf_we", rf_we, 0);
        chk("err.pc", pc, 32'h100);
        chk("err.ir", ir, vecs[5].stim.word);
        chk("err.error", error, 1);
        chk("err.retire", retire_cnt, 1);

        // Fetch timeout: 16 unacknowledged request cycles.
        do_reset();
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("tmo.req_up", imem_req, 1);
        held = 1'b1;
        for (int k = 0; k < 16; k++) begin
            held = held && (imem_req === 1'b1);
            @(negedge clk);
        end
        chk("tmo.held16", held, 1);
        chk("tmo.imem_req", imem_req, 0);
        chk("tmo.error", error, 1);
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        chk("tmo.ir", ir, NOP);
        chk("tmo.pc", pc, 32'h100);

        // Reset in the middle of a data access.
        do_reset();
        run_instr(vecs[0].stim, vecs[0].want, 32'h100, 32'd0, "mid.pre");
        fetch(vecs[1].stim.word, 0, 32'h104, "mid", ok);
        if (ok) begin
            drive_dec(vecs[1].stim);
            @(negedge clk);
            chk("mid.dmem_req", dmem_req, 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("mid.dmem_req_rst", dmem_req, 0);
            chk("mid.pc", pc, 32'h100);
            chk("mid.retire", retire_cnt, 0);
            chk("mid.error", error, 0);
            rst = 1'b0;
            run_instr(vecs[0].stim, vecs[0].want, 32'h100, 32'd0, "mid.restart");
        end

        // Random program against the reference model.
        do_reset();
        pc_m  = 32'h100;
        ret_m = 32'd0;
        for (int r = 0; r < 60; r++) begin
            t = rand_instr();
            e = model(t, pc_m);
            run_instr(t, e, pc_m, ret_m, $sformatf("rnd%0d", r));
            ret_m = ret_m + 32'd1;
            pc_m  = e.pc;
            if (e.err) begin
                do_reset();
                pc_m  = 32'h100;
                ret_m = 32'd0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
